// File: rtl/rc5_decipher.sv
// Iterative RC5-W/R decryption core; oDone after 7R+6 edges (5R+6 with RC5_DEC_FAST_ROUND_EN defined).
// No backpressure: iStart is a level request (low aborts to IDLE), S-table reads have a fixed 2-edge latency.
module rc5_decipher #(
   parameter  int W         = 32,
   parameter  int R         = 12,
   localparam int ROT_VALUE = $clog2(W),
   localparam int T         = 2 * (R + 1),
   localparam int T_LENGTH  = $clog2(T),
   localparam int CNT_W     = $clog2(R + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                iStart,
   input  logic [W-1:0]        iA,
   input  logic [W-1:0]        iB,
   output logic [T_LENGTH-1:0] oS_address1,
   output logic [T_LENGTH-1:0] oS_address2,
   input  logic [W-1:0]        iS_sub_i1,
   input  logic [W-1:0]        iS_sub_i2,
   output logic [W-1:0]        oA_plain,
   output logic [W-1:0]        oB_plain,
   output logic                oDone
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_ADDR, S_WAIT, S_READ,
      S_SUB_B, S_RX_B, S_SUB_A, S_RX_A,
      S_F_ADDR, S_F_WAIT, S_F_READ, S_FINAL, S_DONE,
      S_HALF_B, S_HALF_A
   } state_t;

   state_t              r_state;
   logic [W-1:0]        r_a;
   logic [W-1:0]        r_b;
`ifndef RC5_DEC_FAST_ROUND_EN
   logic [W-1:0]        r_tmp;
`endif
   logic [W-1:0]        r_s0;
   logic [W-1:0]        r_s1;
   logic [CNT_W-1:0]    r_count;
   logic [T_LENGTH-1:0] r_addr1;
   logic [T_LENGTH-1:0] r_addr2;
   logic [W-1:0]        r_a_plain;
   logic [W-1:0]        r_b_plain;
   logic                r_done;

   logic [W-1:0]        w_a_sub;
   logic [W-1:0]        w_b_sub;
   logic [T_LENGTH-1:0] w_addr_even;
   logic [T_LENGTH-1:0] w_addr_odd;

   function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [ROT_VALUE-1:0] n);
      logic [2*W-1:0] w_dbl;
      w_dbl = {x, x} >> n;
      return w_dbl[W-1:0];
   endfunction

   assign w_a_sub     = r_a - r_s0;
   assign w_b_sub     = r_b - r_s1;
   assign w_addr_even = T_LENGTH'({r_count, 1'b0});
   assign w_addr_odd  = w_addr_even | T_LENGTH'(1);

   assign oS_address1 = r_addr1;
   assign oS_address2 = r_addr2;
   assign oA_plain    = r_a_plain;
   assign oB_plain    = r_b_plain;
   assign oDone       = r_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_b       <= '0;
`ifndef RC5_DEC_FAST_ROUND_EN
         r_tmp     <= '0;
`endif
         r_s0      <= '0;
         r_s1      <= '0;
         r_count   <= CNT_W'(R);
         r_addr1   <= '0;
         r_addr2   <= T_LENGTH'(1);
         r_a_plain <= '0;
         r_b_plain <= '0;
         r_done    <= 1'b0;
      end else if (!iStart) begin
         // Dropping the request is a full synchronous abort; a restart always begins at LOAD.
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_b       <= '0;
`ifndef RC5_DEC_FAST_ROUND_EN
         r_tmp     <= '0;
`endif
         r_s0      <= '0;
         r_s1      <= '0;
         r_count   <= CNT_W'(R);
         r_addr1   <= '0;
         r_addr2   <= T_LENGTH'(1);
         r_a_plain <= '0;
         r_b_plain <= '0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_LOAD;
            S_LOAD: begin
               r_a     <= iA;
               r_b     <= iB;
               r_state <= S_ADDR;
            end
            S_ADDR: begin
               r_addr1 <= w_addr_even;
               r_addr2 <= w_addr_odd;
               r_state <= S_WAIT;
            end
            S_WAIT: r_state <= S_READ;
            S_READ: begin
               r_s0    <= iS_sub_i1;
               r_s1    <= iS_sub_i2;
`ifdef RC5_DEC_FAST_ROUND_EN
               r_state <= S_HALF_B;
`else
               r_state <= S_SUB_B;
`endif
            end
`ifdef RC5_DEC_FAST_ROUND_EN
            S_HALF_B: begin
               r_b     <= rotr(w_b_sub, r_a[ROT_VALUE-1:0]) ^ r_a;
               r_state <= S_HALF_A;
            end
            S_HALF_A: begin
               r_a     <= rotr(w_a_sub, r_b[ROT_VALUE-1:0]) ^ r_b;
               r_count <= r_count - CNT_W'(1);
               r_state <= (r_count == CNT_W'(1)) ? S_F_ADDR : S_ADDR;
            end
`else
            S_SUB_B: begin
               r_tmp   <= w_b_sub;
               r_state <= S_RX_B;
            end
            S_RX_B: begin
               r_b     <= rotr(r_tmp, r_a[ROT_VALUE-1:0]) ^ r_a;
               r_state <= S_SUB_A;
            end
            S_SUB_A: begin
               r_tmp   <= w_a_sub;
               r_state <= S_RX_A;
            end
            S_RX_A: begin
               r_a     <= rotr(r_tmp, r_b[ROT_VALUE-1:0]) ^ r_b;
               r_count <= r_count - CNT_W'(1);
               r_state <= (r_count == CNT_W'(1)) ? S_F_ADDR : S_ADDR;
            end
`endif
            S_F_ADDR: begin
               r_addr1 <= '0;
               r_addr2 <= T_LENGTH'(1);
               r_state <= S_F_WAIT;
            end
            S_F_WAIT: r_state <= S_F_READ;
            S_F_READ: begin
               r_s0    <= iS_sub_i1;
               r_s1    <= iS_sub_i2;
               r_state <= S_FINAL;
            end
            S_FINAL: begin
               r_a_plain <= w_a_sub;
               r_b_plain <= w_b_sub;
               r_done    <= 1'b1;
               r_state   <= S_DONE;
            end
            S_DONE:  r_state <= S_DONE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
